// File: rtl/frogger_life_controller_pkg.sv
// Shared definitions for the frogger game-flow blocks: state encodings,
// playfield geometry and the saturating level helper.
package frogger_life_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam int unsigned c_GAME_WIDTH     = 14;
    localparam int unsigned c_GAME_HEIGHT    = 15;
    localparam logic [5:0]  c_GOAL_ROW_DEF   = 6'd0;
    localparam logic [5:0]  c_FROG_START_ROW = 6'd14;
    localparam logic [5:0]  c_FROG_START_COL = 6'd7;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] max_value);
        return (value >= max_value) ? max_value : value + 4'd1;
    endfunction

endpackage

// File: rtl/frogger_tick_timer.sv
// Loadable 4-bit down-counter advanced by the game tick; flags expiry when the
// tick arrives with one tick left. A load on the same edge takes precedence.
module frogger_tick_timer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Load,
    input  logic [3:0] i_Load_Value,
    input  logic       i_Tick,
    output logic       o_Expire
);

    logic [3:0] count_r;

    // Countdown register: load wins over tick, zero holds.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_r <= 4'd0;
        end else if (i_Load) begin
            count_r <= i_Load_Value;
        end else if (i_Tick && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign o_Expire = i_Tick && !i_Load && (count_r == 4'd1);

endmodule

// File: rtl/frogger_life_controller.sv
// Game-flow FSM: turns collision / goal events into DYING and SCORED freezes,
// owns lives and level, and pulses respawn whenever play resumes.
module frogger_life_controller
    import frogger_life_controller_pkg::*;
#(
    parameter int unsigned c_START_LIVES = 3,
    parameter int unsigned c_DEATH_TICKS = 8,
    parameter int unsigned c_SCORE_TICKS = 4,
    parameter int unsigned c_GOAL_ROW    = 0,
    parameter int unsigned c_LEVEL_MAX   = 15
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Tick,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Respawn,
    output logic       o_Freeze,
    output logic       o_Blink,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    localparam logic [2:0] c_LIVES_INIT = 3'(c_START_LIVES);
    localparam logic [3:0] c_DEATH_LOAD = 4'(c_DEATH_TICKS);
    localparam logic [3:0] c_SCORE_LOAD = 4'(c_SCORE_TICKS);
    localparam logic [5:0] c_GOAL_Y     = 6'(c_GOAL_ROW);
    localparam logic [3:0] c_LEVEL_TOP  = 4'(c_LEVEL_MAX);

    state_e     state_r;
    logic [2:0] lives_r;
    logic [3:0] level_r;
    logic       respawn_r;
    logic       freeze_r;
    logic       blink_r;
    logic       game_over_r;

    logic       goal_s;
    logic       timer_load_s;
    logic [3:0] timer_value_s;
    logic       timer_expire_s;

    assign goal_s = (i_Frogger_Y == c_GOAL_Y);

    // Timer load decode: only leaving PLAY arms the freeze timer, collision first.
    always_comb begin
        timer_load_s  = 1'b0;
        timer_value_s = 4'd0;
        if (state_r == ST_PLAY) begin
            if (i_Collided) begin
                timer_load_s  = 1'b1;
                timer_value_s = c_DEATH_LOAD;
            end else if (goal_s) begin
                timer_load_s  = 1'b1;
                timer_value_s = c_SCORE_LOAD;
            end else begin
                timer_load_s  = 1'b0;
                timer_value_s = 4'd0;
            end
        end else begin
            timer_load_s  = 1'b0;
            timer_value_s = 4'd0;
        end
    end

    frogger_tick_timer u_timer (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Load       (timer_load_s),
        .i_Load_Value (timer_value_s),
        .i_Tick       (i_Tick),
        .o_Expire     (timer_expire_s)
    );

    // Game-flow FSM with lives, level and all registered status outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r     <= ST_IDLE;
            lives_r     <= c_LIVES_INIT;
            level_r     <= 4'd0;
            respawn_r   <= 1'b0;
            freeze_r    <= 1'b1;
            blink_r     <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            respawn_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_r   <= ST_PLAY;
                        lives_r   <= c_LIVES_INIT;
                        level_r   <= 4'd0;
                        respawn_r <= 1'b1;
                        freeze_r  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (i_Collided) begin
                        state_r  <= ST_DYING;
                        lives_r  <= lives_r - 3'd1;
                        freeze_r <= 1'b1;
                    end else if (goal_s) begin
                        state_r  <= ST_SCORED;
                        level_r  <= sat_inc4(level_r, c_LEVEL_TOP);
                        freeze_r <= 1'b1;
                    end
                end
                ST_DYING: begin
                    // The expiring tick clears blink instead of toggling it.
                    if (timer_expire_s) begin
                        blink_r <= 1'b0;
                        if (lives_r == 3'd0) begin
                            state_r     <= ST_GAME_OVER;
                            game_over_r <= 1'b1;
                        end else begin
                            state_r   <= ST_PLAY;
                            respawn_r <= 1'b1;
                            freeze_r  <= 1'b0;
                        end
                    end else if (i_Tick) begin
                        blink_r <= ~blink_r;
                    end
                end
                ST_SCORED: begin
                    if (timer_expire_s) begin
                        state_r   <= ST_PLAY;
                        respawn_r <= 1'b1;
                        freeze_r  <= 1'b0;
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Start) begin
                        state_r     <= ST_PLAY;
                        lives_r     <= c_LIVES_INIT;
                        level_r     <= 4'd0;
                        respawn_r   <= 1'b1;
                        freeze_r    <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    freeze_r    <= 1'b1;
                    blink_r     <= 1'b0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_Respawn   = respawn_r;
    assign o_Freeze    = freeze_r;
    assign o_Blink     = blink_r;
    assign o_Lives     = lives_r;
    assign o_Level     = level_r;
    assign o_Game_Over = game_over_r;
    assign o_State     = state_r;

endmodule

// File: tb/tb_frogger_life_controller.sv
// Scoreboard bench: a rule-level game model predicts every cycle's outputs,
// a separate monitor compares them against the controller.
module tb_frogger_life_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       collided = 1'b0;
    logic [5:0] frog_y = 6'd5;

    logic       respawn, freeze, blink, game_over;
    logic [2:0] lives, state;
    logic [3:0] level;

    frogger_life_controller dut (
        .i_Clk       (clk),
        .i_Reset     (reset),
        .i_Tick      (tick),
        .i_Start     (start),
        .i_Collided  (collided),
        .i_Frogger_Y (frog_y),
        .o_Respawn   (respawn),
        .o_Freeze    (freeze),
        .o_Blink     (blink),
        .o_Lives     (lives),
        .o_Level     (level),
        .o_Game_Over (game_over),
        .o_State     (state)
    );

    always #5 clk = ~clk;

    // Expected outputs: state, lives, level, respawn, freeze, blink, game_over.
    typedef struct packed {
        logic [2:0] st;
        logic [2:0] lv;
        logic [3:0] lvl;
        logic       rsp;
        logic       frz;
        logic       blk;
        logic       go;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    // Reference model: game rules in plain integers.
    int m_mode = 0;   // 0 idle, 1 play, 2 dying, 3 scored, 4 game over
    int m_lives = 3;
    int m_level = 0;
    int m_left = 0;   // freeze ticks still to wait
    int m_blink = 0;

    task automatic model_step(input bit r, input bit s, input bit t, input bit c, input int y);
        int rsp;
        obs_t e;
        rsp = 0;
        if (r) begin
            m_mode = 0; m_lives = 3; m_level = 0; m_left = 0; m_blink = 0;
        end else if (m_mode == 0) begin
            if (s) begin m_mode = 1; rsp = 1; end
        end else if (m_mode == 1) begin
            if (c) begin
                m_lives = m_lives - 1; m_left = 8; m_mode = 2;
            end else if (y == 0) begin
                m_level = (m_level < 15) ? m_level + 1 : 15; m_left = 4; m_mode = 3;
            end
        end else if (m_mode == 2 || m_mode == 3) begin
            if (t) begin
                if (m_left == 1) begin
                    m_left = 0;
                    m_blink = 0;
                    if (m_mode == 2 && m_lives == 0) m_mode = 4;
                    else begin m_mode = 1; rsp = 1; end
                end else begin
                    m_left = m_left - 1;
                    if (m_mode == 2) m_blink = 1 - m_blink;
                end
            end
        end else if (m_mode == 4) begin
            if (s) begin m_lives = 3; m_level = 0; m_mode = 1; rsp = 1; end
        end
        e.st  = 3'(m_mode);
        e.lv  = 3'(m_lives);
        e.lvl = 4'(m_level);
        e.rsp = (rsp != 0);
        e.frz = (m_mode != 1);
        e.blk = (m_blink != 0);
        e.go  = (m_mode == 4);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs away from the active edge and predict the result.
    task automatic cyc(input bit r, input bit s, input bit t, input bit c, input int y);
        @(negedge clk);
        reset = r; start = s; tick = t; collided = c; frog_y = 6'(y);
        model_step(r, s, t, c, y);
    endtask

    // Monitor: after each active edge compare DUT outputs with the next expectation.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: state, lv: lives, lvl: level, rsp: respawn, frz: freeze, blk: blink, go: game_over};
                n_checks++;
                if (a !== e)
                    $display("FAIL cycle_outputs t=%0t got st=%0d lives=%0d lvl=%0d rsp=%b frz=%b blk=%b go=%b expected st=%0d lives=%0d lvl=%0d rsp=%b frz=%b blk=%b go=%b",
                             $time, a.st, a.lv, a.lvl, a.rsp, a.frz, a.blk, a.go,
                             e.st, e.lv, e.lvl, e.rsp, e.frz, e.blk, e.go);
                else
                    n_passed++;
            end
        end
    end

    initial begin
        // Reset, then start.
        cyc(1, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 5);
        cyc(0, 1, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);

        // Held collision across the whole freeze, ticks every other cycle.
        for (int i = 0; i < 20; i++) cyc(0, 0, (i % 2) == 1, 1, 5);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 5);

        // Separate collisions until game over, then restart.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 5);
            for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 5);
        end
        cyc(0, 1, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);

        // Collision and goal in the same cycle.
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 5);

        // Sixteen-plus goal reaches with frog parked on the goal row.
        for (int i = 0; i < 300; i++) cyc(0, 0, (i % 3) == 0, 0, 0);
        cyc(0, 0, 0, 0, 5);

        // Reset on the third tick of DYING while start is held.
        cyc(0, 0, 0, 1, 5);
        cyc(0, 0, 1, 0, 5);
        cyc(0, 0, 1, 0, 5);
        cyc(1, 1, 1, 0, 5);
        cyc(0, 0, 0, 0, 5);
        cyc(0, 1, 0, 0, 5);

        // Randomized play.
        for (int i = 0; i < 2000; i++)
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 13))));

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
        else
            n_passed++;
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
